// File: rtl/riscv_ifetch_if.sv
// Fetch-side bundle: PC request, ROM read port, decode handshake and flush.
interface riscv_ifetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              pc_ready;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              flush;

    modport slave (
        input  pc_addr, pc_valid, mem_rdata, instr_ready, flush,
        output pc_ready, mem_rd_en, mem_addr, instr, instr_pc, instr_valid
    );

    modport master (
        output pc_addr, pc_valid, mem_rdata, instr_ready, flush,
        input  pc_ready, mem_rd_en, mem_addr, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/riscv_ifetch.sv
// Credit-based instruction fetch: issues ROM reads only when a buffer slot
// is reserved, buffers returned words with their PC, and hands them to decode.
module riscv_ifetch #(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic            clk,
    input logic            rst,
    riscv_ifetch_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0]              occ;
    logic                          inflight;
    logic [PTR_W-1:0]              wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]             tag;
    logic [DEPTH-1:0][DATA_W-1:0]  data_q;
    logic [DEPTH-1:0][ADDR_W-1:0]  pc_q;
    logic                          accept, push, pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit check uses only registered state, so decode back-pressure
    // never reaches the PC enable combinationally.
    assign bus.pc_ready    = !rst && !bus.flush && ((32'(occ) + 32'(inflight)) < 32'(DEPTH));
    assign accept          = bus.pc_valid && bus.pc_ready;
    assign bus.mem_rd_en   = accept;
    assign bus.mem_addr    = bus.pc_addr;

    assign bus.instr_valid = !rst && (occ != '0);
    assign bus.instr       = data_q[rd_ptr];
    assign bus.instr_pc    = pc_q[rd_ptr];

    assign push = inflight;
    assign pop  = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag      <= '0;
            data_q   <= '0;
            pc_q     <= '0;
        end else if (bus.flush) begin
            // The return and pop landing in this cycle are dropped along
            // with everything already buffered.
            occ      <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= accept;
            if (accept) tag <= bus.pc_addr;
            if (push) begin
                data_q[wr_ptr] <= bus.mem_rdata;
                pc_q[wr_ptr]   <= tag;
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end
endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch (DEPTH=3 main instance, DEPTH=2 side instance).
module tb_riscv_ifetch;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    riscv_ifetch_if #(.ADDR_W(8), .DATA_W(32)) b ();
    riscv_ifetch_if #(.ADDR_W(8), .DATA_W(32)) b2 ();

    riscv_ifetch #(.DEPTH(3), .ADDR_W(8), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(b));
    riscv_ifetch #(.DEPTH(2), .ADDR_W(8), .DATA_W(32)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents: word i holds 32'h13 + i.
    function automatic logic [31:0] rom(input logic [7:0] a);
        return 32'h00000013 + 32'(a);
    endfunction

    always @(posedge clk) begin
        if (b.mem_rd_en)  b.mem_rdata  <= rom(b.mem_addr);
        if (b2.mem_rd_en) b2.mem_rdata <= rom(b2.mem_addr);
    end

    // Writing into a full buffer with no pop in the same cycle is illegal.
    always @(posedge clk) begin
        if (!rst && !b.flush && dut.inflight && dut.occ == 2'd3 &&
            !(b.instr_valid && b.instr_ready)) begin
            mismatched++;
            $display("FAIL overflow occ=%0d inflight=%0b", dut.occ, dut.inflight);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b.pc_valid = 1'b0; b.pc_addr = 8'h00; b.instr_ready = 1'b0; b.flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        b2.pc_valid = 1'b0; b2.pc_addr = 8'h00; b2.instr_ready = 1'b0; b2.flush = 1'b0;
        tick(); tick();
        compared++; if (b.instr_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid actual=%0b expected=0", b.instr_valid); end
        compared++; if (b.pc_ready !== 1'b0) begin mismatched++; $display("FAIL reset_pc_ready actual=%0b expected=0", b.pc_ready); end
        compared++; if (b.instr !== 32'h0) begin mismatched++; $display("FAIL reset_instr actual=%h expected=00000000", b.instr); end
        compared++; if (b.instr_pc !== 8'h0) begin mismatched++; $display("FAIL reset_instr_pc actual=%h expected=00", b.instr_pc); end
        rst = 1'b0;
        #1;
        compared++; if (b.pc_ready !== 1'b1) begin mismatched++; $display("FAIL reset_release_ready actual=%0b expected=1", b.pc_ready); end
        tick();
    endtask

    task automatic test_streaming();
        b.instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b.pc_valid = (i < 4);
            b.pc_addr  = 8'(i);
            #1;
            if (i < 4) begin
                compared++; if (b.pc_ready !== 1'b1) begin mismatched++; $display("FAIL stream_ready c%0d actual=%0b expected=1", i, b.pc_ready); end
                compared++; if (b.mem_rd_en !== 1'b1 || b.mem_addr !== 8'(i)) begin mismatched++; $display("FAIL stream_rd c%0d actual=%0b/%h expected=1/%h", i, b.mem_rd_en, b.mem_addr, 8'(i)); end
            end
            if (i < 2) begin
                compared++; if (b.instr_valid !== 1'b0) begin mismatched++; $display("FAIL stream_latency c%0d actual=%0b expected=0", i, b.instr_valid); end
            end else begin
                compared++; if (b.instr_valid !== 1'b1 || b.instr !== 32'h13 + 32'(i - 2) || b.instr_pc !== 8'(i - 2))
                    begin mismatched++; $display("FAIL stream_out c%0d actual=%0b/%h/%h expected=1/%h/%h", i, b.instr_valid, b.instr, b.instr_pc, 32'h13 + 32'(i - 2), 8'(i - 2)); end
            end
            tick();
        end
        compared++; if (b.instr_valid !== 1'b0) begin mismatched++; $display("FAIL stream_drain actual=%0b expected=0", b.instr_valid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int acc;
        acc = 0;
        b.instr_ready = 1'b0;
        b.pc_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b.pc_addr = 8'(10 + acc);
            #1;
            if (b.pc_ready) acc++;
            tick();
        end
        compared++; if (acc !== 3) begin mismatched++; $display("FAIL bp_accepts actual=%0d expected=3", acc); end
        compared++; if (b.pc_ready !== 1'b0) begin mismatched++; $display("FAIL bp_full_ready actual=%0b expected=0", b.pc_ready); end
        compared++; if (b.instr_pc !== 8'd10 || b.instr !== 32'h1D) begin mismatched++; $display("FAIL bp_hold actual=%h/%h expected=0a/0000001d", b.instr_pc, b.instr); end
        // Release: pops 10,11,12 then the newly issued pc 20.
        b.instr_ready = 1'b1;
        b.pc_addr = 8'd20;
        #1;
        compared++; if (b.pc_ready !== 1'b0 || b.instr_pc !== 8'd10) begin mismatched++; $display("FAIL bp_rel0 actual=%0b/%h expected=0/0a", b.pc_ready, b.instr_pc); end
        tick();
        #1;
        compared++; if (b.pc_ready !== 1'b1 || b.instr_pc !== 8'd11) begin mismatched++; $display("FAIL bp_rel1 actual=%0b/%h expected=1/0b", b.pc_ready, b.instr_pc); end
        tick();
        b.pc_valid = 1'b0;
        #1;
        compared++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 8'd12) begin mismatched++; $display("FAIL bp_rel2 actual=%0b/%h expected=1/0c", b.instr_valid, b.instr_pc); end
        tick();
        compared++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 8'd20 || b.instr !== 32'h27) begin mismatched++; $display("FAIL bp_resume actual=%0b/%h/%h expected=1/14/00000027", b.instr_valid, b.instr_pc, b.instr); end
        tick();
        compared++; if (b.instr_valid !== 1'b0) begin mismatched++; $display("FAIL bp_empty actual=%0b expected=0", b.instr_valid); end
        idle_inputs();
        tick();
    endtask

    task automatic fill_two_plus_inflight(input logic [7:0] base);
        b.instr_ready = 1'b0;
        b.pc_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b.pc_addr = base + 8'(k);
            tick();
        end
    endtask

    task automatic test_flush();
        fill_two_plus_inflight(8'd3);
        b.flush = 1'b1;
        b.pc_addr = 8'd40;
        #1;
        compared++; if (b.pc_ready !== 1'b0 || b.mem_rd_en !== 1'b0) begin mismatched++; $display("FAIL flush_ready actual=%0b/%0b expected=0/0", b.pc_ready, b.mem_rd_en); end
        compared++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 8'd3) begin mismatched++; $display("FAIL flush_pre actual=%0b/%h expected=1/03", b.instr_valid, b.instr_pc); end
        tick();
        b.flush = 1'b0;
        #1;
        compared++; if (b.instr_valid !== 1'b0 || b.pc_ready !== 1'b1) begin mismatched++; $display("FAIL flush_after actual=%0b/%0b expected=0/1", b.instr_valid, b.pc_ready); end
        tick();
        b.pc_valid = 1'b0;
        compared++; if (b.instr_valid !== 1'b0) begin mismatched++; $display("FAIL flush_stale actual=%0b expected=0", b.instr_valid); end
        tick();
        compared++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 8'd40 || b.instr !== 32'h3B) begin mismatched++; $display("FAIL flush_new actual=%0b/%h/%h expected=1/28/0000003b", b.instr_valid, b.instr_pc, b.instr); end
        b.instr_ready = 1'b1;
        tick();
        compared++; if (b.instr_valid !== 1'b0) begin mismatched++; $display("FAIL flush_no_pc5 actual=%0b/%h expected=0", b.instr_valid, b.instr_pc); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midstream();
        fill_two_plus_inflight(8'd6);
        b.pc_valid = 1'b0;
        rst = 1'b1;
        #1;
        compared++; if (b.instr_valid !== 1'b0 || b.pc_ready !== 1'b0) begin mismatched++; $display("FAIL rstmid_during actual=%0b/%0b expected=0/0", b.instr_valid, b.pc_ready); end
        tick();
        rst = 1'b0;
        #1;
        compared++; if (b.instr_valid !== 1'b0 || b.pc_ready !== 1'b1 || b.instr_pc !== 8'd0) begin mismatched++; $display("FAIL rstmid_after actual=%0b/%0b/%h expected=0/1/00", b.instr_valid, b.pc_ready, b.instr_pc); end
        tick();
        compared++; if (b.instr_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_late_data actual=%0b expected=0", b.instr_valid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_boundary();
        b.instr_ready = 1'b1;
        b.pc_valid = 1'b1;
        b.pc_addr = 8'hFF;
        tick();
        b.pc_addr = 8'h00;
        tick();
        b.pc_valid = 1'b0;
        compared++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 8'hFF || b.instr !== 32'h112) begin mismatched++; $display("FAIL bound_ff actual=%0b/%h/%h expected=1/ff/00000112", b.instr_valid, b.instr_pc, b.instr); end
        tick();
        compared++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 8'h00 || b.instr !== 32'h13) begin mismatched++; $display("FAIL bound_00 actual=%0b/%h/%h expected=1/00/00000013", b.instr_valid, b.instr_pc, b.instr); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_depth2();
        logic [8:0] exp_rdy;
        logic [8:0] exp_vld;
        int nacc, ndel;
        exp_rdy = 9'b011011011;
        exp_vld = 9'b101101100;
        nacc = 0;
        ndel = 0;
        b2.instr_ready = 1'b1;
        b2.pc_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            b2.pc_addr = 8'(nacc);
            #1;
            compared++; if (b2.pc_ready !== exp_rdy[c] || b2.instr_valid !== exp_vld[c])
                begin mismatched++; $display("FAIL d2_pattern c%0d actual=%0b/%0b expected=%0b/%0b", c, b2.pc_ready, b2.instr_valid, exp_rdy[c], exp_vld[c]); end
            if (b2.instr_valid) begin
                compared++; if (b2.instr_pc !== 8'(ndel)) begin mismatched++; $display("FAIL d2_order c%0d actual=%h expected=%h", c, b2.instr_pc, 8'(ndel)); end
                ndel++;
            end
            if (b2.pc_ready) nacc++;
            tick();
        end
        compared++; if (nacc !== 6 || ndel !== 5) begin mismatched++; $display("FAIL d2_rate actual=%0d/%0d expected=6/5", nacc, ndel); end
        b2.pc_valid = 1'b0;
        tick();
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_streaming();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_boundary();
        test_depth2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/riscv_ifetch.md
Name: riscv_ifetch

Overview:
- Instruction-fetch responder on the consumer side of the program counter: accepts 8-bit word-index PC values, reads a synchronous instruction ROM with 1-cycle latency, and buffers the returned words.
- Presents each instruction with its PC to decode through a valid/ready handshake.
- Credit-based issue: no read is ever issued unless buffer space is already reserved for its data.
- `flush` discards every buffered and in-flight fetch when a branch redirects the PC.

Parameters:
- DEPTH, 3, instruction buffer entries. Legal range 2..8. 3 sustains 1 instruction/cycle; 2 sustains 2/3.
- ADDR_W, 8, PC word-index width; matches the PC output.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pc_addr  in  ADDR_W  word-index address from the PC
- pc_valid  in  1  pc_addr is valid this cycle
- pc_ready  out  1  fetch accepts pc_addr this cycle; doubles as the PC enable
- mem_rd_en  out  1  ROM read strobe; equals pc_valid & pc_ready
- mem_addr  out  ADDR_W  ROM address; combinationally equals pc_addr
- mem_rdata  in  DATA_W  ROM data, valid on the cycle after mem_rd_en
- instr  out  DATA_W  instruction at the buffer head
- instr_pc  out  ADDR_W  word-index PC of instr
- instr_valid  out  1  buffer non-empty
- instr_ready  in  1  decode consumes the head this cycle
- flush  in  1  discard all buffered and in-flight fetches

Behaviour:
- **Reset:**
  - Synchronous; rst high at a rising edge clears buffer occupancy (occ), in-flight flag (inflight), read/write pointers, instr, and instr_pc to 0.
  - instr_valid = 0 and pc_ready = 0 while rst is high.
  - A reset asserted mid-operation drops all buffered and in-flight fetches. A ROM return arriving the cycle after reset is ignored.
- **Accept:**
  - pc_ready = !rst & !flush & (occ + inflight < DEPTH); registered terms only, so there is no combinational path from instr_ready.
  - An accept (pc_valid & pc_ready) drives mem_rd_en = 1, sets inflight for the next cycle, and captures pc_addr into a tag register.
- **Return:**
  - The cycle after an accept, mem_rdata and the tag are written at the write pointer and occ increments, unless flush or rst is high in that return cycle.
  - Latency: pc accepted at cycle N, so instr_valid = 1 with that word at cycle N+2, given an empty buffer.
- **Output:**
  - instr and instr_pc are driven from registered buffer storage at the read pointer.
  - instr_valid = (occ != 0).
  - While instr_valid & !instr_ready, instr and instr_pc hold stable.
  - Pop when instr_valid & instr_ready.
- **Simultaneous events:**
  - Return and pop in the same cycle: occ is unchanged and both pointers advance.
  - Accept and pop in the same cycle are legal.
- **Flush:**
  - Takes effect at the clock edge: occ := 0, inflight := 0, pointers := 0.
  - The pop and return occurring in the flush cycle are discarded.
  - pc_ready = 0 in the flush cycle.
  - instr_valid = 0 on the following cycle.
- **Wrap-around:**
  - Pointers are modulo DEPTH, wrapping from DEPTH-1 to 0; DEPTH is not required to be a power of 2.
  - Addresses are unsigned; pc_addr 8'hFF is fetched normally with no special wrap handling.
- **Overflow:** occ never exceeds DEPTH. Any write while full is a design error; the bench asserts it never occurs.
- **Stall:** with instr_ready low, at most DEPTH words are accepted, then pc_ready stays low until a pop.

Test Plan:
- **Reset mid-stream:** rst high for 1 cycle while occ = 2 and inflight = 1 -> next cycle instr_valid = 0, pc_ready = 1; the late mem_rdata is not buffered.
- **Streaming:** pc_addr 0,1,2,3 on consecutive cycles, ROM[i] = 32'h00000013 + i, instr_ready = 1 -> instr_valid from cycle 2; instr = 32'h13, 32'h14, 32'h15, 32'h16 on consecutive cycles with instr_pc 0..3; pc_ready stays 1.
- **Back-pressure:** instr_ready = 0, pc_valid = 1 continuously -> exactly 3 accepts, then pc_ready = 0. After instr_ready = 1, the words are popped in order 0,1,2 and issue resumes.
- **Flush:** flush while occ = 2 and a read is in flight (pc 5) -> next cycle instr_valid = 0. A new pc 40 accepted after flush yields instr_pc = 40 as the first output; pc 5 never appears.
- **DEPTH = 2:** with continuous pc_valid and instr_ready, pc_ready toggles in a 2-of-3 cycle pattern -> 2 instructions delivered per 3 cycles.
- **Boundary address:** pc_addr = 8'hFF followed by 8'h00 -> instr_pc = 8'hFF then 8'h00 with the corresponding ROM words.
